reg_op_sequencer: RTL

Command-driven controller that sits on the initiator side of the 8x16 register file. It drives the two read-address ports, captures the operands, runs a small ALU operation and issues the write-back through regIn/regInAddr/regInWE. After every reset it clears all registers. It is the sequencing front end of the Rechenwerk datapath.

---
 rtl/reg_op_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/reg_op_sequencer.sv
// Command sequencer for the 8x16 register file: clears all registers after reset,
// then runs fetch / execute / write-back for one ALU command at a time.
module reg_op_sequencer #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 3,
   parameter int NUM_REGS   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmdValid,
   output logic                  cmdReady,
   input  logic [2:0]            cmdOp,
   input  logic [ADDR_WIDTH-1:0] cmdDst,
   input  logic [ADDR_WIDTH-1:0] cmdSrcA,
   input  logic [ADDR_WIDTH-1:0] cmdSrcB,
   input  logic [DATA_WIDTH-1:0] cmdImm,
   output logic [ADDR_WIDTH-1:0] regOut1Addr,
   output logic [ADDR_WIDTH-1:0] regOut2Addr,
   input  logic [DATA_WIDTH-1:0] regOut1,
   input  logic [DATA_WIDTH-1:0] regOut2,
   output logic [DATA_WIDTH-1:0] regIn,
   output logic [ADDR_WIDTH-1:0] regInAddr,
   output logic                  regInWE,
   output logic [DATA_WIDTH-1:0] resultOut,
   output logic                  resultValid,
   output logic                  carry,
   output logic                  zero,
   output logic                  initDone,
   output logic                  busy
);

   localparam int CNT_W = $clog2(NUM_REGS) + 1;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_MOV  = 3'b101;
   localparam logic [2:0] OP_LDI  = 3'b110;
   localparam logic [2:0] OP_READ = 3'b111;

   typedef enum logic [2:0] {INIT, IDLE, FETCH, EXEC, WB} state_t;

   state_t                state;
   logic [CNT_W-1:0]      init_cnt;
   logic [2:0]            op;
   logic [ADDR_WIDTH-1:0] dst;
   logic [DATA_WIDTH-1:0] imm;
   logic [DATA_WIDTH-1:0] opnd_a;
   logic [DATA_WIDTH-1:0] opnd_b;

   logic [DATA_WIDTH:0]   alu_sum;
   logic [DATA_WIDTH-1:0] alu_result;
   logic                  alu_carry;

   // carry defaults to its held value so only ADD/SUB can change it
   always_comb begin
      alu_sum    = {1'b0, opnd_a} + {1'b0, opnd_b};
      alu_result = '0;
      alu_carry  = carry;
      case (op)
         OP_ADD: begin
            alu_result = alu_sum[DATA_WIDTH-1:0];
            alu_carry  = alu_sum[DATA_WIDTH];
         end
         OP_SUB: begin
            alu_result = opnd_a - opnd_b;
            alu_carry  = (opnd_a < opnd_b);
         end
         OP_AND:  alu_result = opnd_a & opnd_b;
         OP_OR:   alu_result = opnd_a | opnd_b;
         OP_XOR:  alu_result = opnd_a ^ opnd_b;
         OP_MOV:  alu_result = opnd_a;
         OP_LDI:  alu_result = imm;
         OP_READ: alu_result = opnd_a;
         default: alu_result = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= INIT;
         init_cnt    <= '0;
         op          <= '0;
         dst         <= '0;
         imm         <= '0;
         opnd_a      <= '0;
         opnd_b      <= '0;
         cmdReady    <= 1'b0;
         regOut1Addr <= '0;
         regOut2Addr <= '0;
         regIn       <= '0;
         regInAddr   <= '0;
         regInWE     <= 1'b0;
         resultOut   <= '0;
         resultValid <= 1'b0;
         carry       <= 1'b0;
         zero        <= 1'b0;
         initDone    <= 1'b0;
         busy        <= 1'b0;
      end else begin
         regInWE     <= 1'b0;
         resultValid <= 1'b0;
         case (state)
            INIT: begin
               if (init_cnt == CNT_W'(NUM_REGS)) begin
                  state    <= IDLE;
                  initDone <= 1'b1;
                  cmdReady <= 1'b1;
                  busy     <= 1'b0;
               end else begin
                  regInWE   <= 1'b1;
                  regInAddr <= init_cnt[ADDR_WIDTH-1:0];
                  regIn     <= '0;
                  init_cnt  <= init_cnt + 1'b1;
                  busy      <= 1'b1;
               end
            end
            // read addresses are launched here so they are valid for the whole FETCH cycle
            IDLE: begin
               if (cmdValid && cmdReady) begin
                  op          <= cmdOp;
                  dst         <= cmdDst;
                  imm         <= cmdImm;
                  regOut1Addr <= cmdSrcA;
                  regOut2Addr <= cmdSrcB;
                  cmdReady    <= 1'b0;
                  busy        <= 1'b1;
                  state       <= FETCH;
               end
            end
            FETCH: begin
               opnd_a <= regOut1;
               opnd_b <= regOut2;
               state  <= EXEC;
            end
            EXEC: begin
               resultOut   <= alu_result;
               resultValid <= 1'b1;
               regIn       <= alu_result;
               regInAddr   <= dst;
               regInWE     <= (op != OP_READ);
               carry       <= alu_carry;
               zero        <= (alu_result == '0);
               state       <= WB;
            end
            WB: begin
               cmdReady <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule
